jpeg_dec_controller: RTL and testbench



---
 rtl/jpeg_dec_pkg.sv | 40 ++++
 rtl/jpeg_dec_controller_if.sv | 30 +++
 rtl/jpeg_stage_watchdog.sv | 26 ++
 rtl/jpeg_dec_controller.sv | 95 +++++++++
 tb/tb_jpeg_dec_controller.sv | 189 ++++++++++++++++++
 5 files changed

// File: rtl/jpeg_dec_pkg.sv
// Shared types and defaults for the JPEG decode-path controller and its watchdog.
package jpeg_dec_pkg;

   typedef enum logic [3:0] {
      S_IDLE   = 4'd0,
      S_HUFF   = 4'd1,
      S_DEQUAN = 4'd2,
      S_IDCT   = 4'd3,
      S_YCC    = 4'd4,
      S_NEXT   = 4'd5,
      S_DONE   = 4'd6,
      S_ERR    = 4'd7
   } state_t;

   typedef enum logic [1:0] {
      STG_HUFF   = 2'd0,
      STG_DEQUAN = 2'd1,
      STG_IDCT   = 2'd2,
      STG_YCC    = 2'd3
   } stage_t;

   localparam int unsigned DEF_NUM_BLOCKS = 64;
   localparam int unsigned DEF_TIMEOUT    = 1024;

   function automatic int unsigned idx_width(input int unsigned n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

   // One-hot {ycc, idct, dequan, huff} of the stage a state drives; zero outside stage states.
   function automatic logic [3:0] stage_mask(input state_t s);
      case (s)
         S_HUFF:   return 4'b0001 << STG_HUFF;
         S_DEQUAN: return 4'b0001 << STG_DEQUAN;
         S_IDCT:   return 4'b0001 << STG_IDCT;
         S_YCC:    return 4'b0001 << STG_YCC;
         default:  return 4'b0000;
      endcase
   endfunction

endpackage

// File: rtl/jpeg_dec_controller_if.sv
// Enable/valid pins plus the four start/done handshakes of the decode datapath.
interface jpeg_dec_controller_if #(
   parameter int unsigned BW = 6
);
   logic          enable;
   logic          start_huff;
   logic          done_huff;
   logic          start_dequan;
   logic          done_dequan;
   logic          start_idct;
   logic          done_idct;
   logic          start_ycc2rgb;
   logic          done_ycc2rgb;
   logic [BW-1:0] block_idx;
   logic          busy;
   logic          valid;
   logic          error;

   modport master (
      input  enable, done_huff, done_dequan, done_idct, done_ycc2rgb,
      output start_huff, start_dequan, start_idct, start_ycc2rgb,
             block_idx, busy, valid, error
   );

   modport slave (
      output enable, done_huff, done_dequan, done_idct, done_ycc2rgb,
      input  start_huff, start_dequan, start_idct, start_ycc2rgb,
             block_idx, busy, valid, error
   );
endinterface

// File: rtl/jpeg_stage_watchdog.sv
// Per-stage cycle counter; expired is high once TIMEOUT-1 cycles have been counted since clear.
module jpeg_stage_watchdog
   import jpeg_dec_pkg::*;
#(
   parameter int unsigned TIMEOUT = DEF_TIMEOUT
) (
   input  logic clk,
   input  logic rst,
   input  logic clear,
   input  logic count_en,
   output logic expired
);
   localparam int unsigned CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

   logic [CW-1:0] count;

   always_ff @(posedge clk) begin
      if (rst || clear) begin
         count <= '0;
      end else if (count_en && !expired) begin
         count <= count + CW'(1);
      end
   end

   assign expired = (count == CW'(TIMEOUT - 1));
endmodule

// File: rtl/jpeg_dec_controller.sv
// Frame sequencer for the JPEG decode path: each block goes Huffman -> dequant -> IDCT -> YCbCr-to-RGB,
// with one-cycle start/done handshakes, a per-stage watchdog and a one-cycle frame valid.
module jpeg_dec_controller
   import jpeg_dec_pkg::*;
#(
   parameter int unsigned NUM_BLOCKS = DEF_NUM_BLOCKS,
   parameter int unsigned TIMEOUT    = DEF_TIMEOUT,
   parameter int unsigned BW         = idx_width(NUM_BLOCKS)
) (
   input logic                   clk,
   input logic                   rst,
   jpeg_dec_controller_if.master bus
);
   state_t        state, state_nx;
   logic [3:0]    done_v, cur_mask, start_q, start_d;
   logic [BW-1:0] idx_q, idx_d;
   logic          busy_q, busy_d, valid_q, valid_d, error_q, error_d;
   logic          accept, frame_start, last_block, wd_expired;

   assign done_v      = {bus.done_ycc2rgb, bus.done_idct, bus.done_dequan, bus.done_huff};
   assign cur_mask    = stage_mask(state);
   // start_q marks the first cycle of a stage, so a done coincident with start is ignored
   assign accept      = |(cur_mask & done_v & ~start_q);
   assign last_block  = (idx_q == BW'(NUM_BLOCKS - 1));
   assign frame_start = (state == S_IDLE) && bus.enable;

   jpeg_stage_watchdog #(.TIMEOUT(TIMEOUT)) u_watchdog (
      .clk      (clk),
      .rst      (rst),
      .clear    (state_nx != state),
      .count_en (|cur_mask),
      .expired  (wd_expired)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state   <= S_IDLE;
         start_q <= '0;
         idx_q   <= '0;
         busy_q  <= 1'b0;
         valid_q <= 1'b0;
         error_q <= 1'b0;
      end else begin
         state   <= state_nx;
         start_q <= start_d;
         idx_q   <= idx_d;
         busy_q  <= busy_d;
         valid_q <= valid_d;
         error_q <= error_d;
      end
   end

   // An accepted done takes priority over watchdog expiry in the same cycle
   always_comb begin
      state_nx = state;
      case (state)
         S_IDLE:   if (bus.enable) state_nx = S_HUFF;
         S_HUFF:   if (accept) state_nx = S_DEQUAN; else if (wd_expired) state_nx = S_ERR;
         S_DEQUAN: if (accept) state_nx = S_IDCT;   else if (wd_expired) state_nx = S_ERR;
         S_IDCT:   if (accept) state_nx = S_YCC;    else if (wd_expired) state_nx = S_ERR;
         S_YCC:    if (accept) state_nx = S_NEXT;   else if (wd_expired) state_nx = S_ERR;
         S_NEXT:   state_nx = last_block ? S_DONE : S_HUFF;
         S_DONE:   state_nx = S_IDLE;
         S_ERR:    if (!bus.enable) state_nx = S_IDLE;
         default:  state_nx = S_IDLE;
      endcase
   end

   always_comb begin
      start_d = (state_nx != state) ? stage_mask(state_nx) : '0;
      busy_d  = (state_nx != S_IDLE);
      valid_d = (state_nx == S_DONE);
      idx_d   = idx_q;
      if (frame_start) begin
         idx_d = '0;
      end else if ((state == S_NEXT) && !last_block) begin
         idx_d = idx_q + BW'(1);
      end
      error_d = error_q;
      if (state_nx == S_ERR) begin
         error_d = 1'b1;
      end else if (frame_start) begin
         error_d = 1'b0;
      end
   end

   assign bus.start_huff    = start_q[STG_HUFF];
   assign bus.start_dequan  = start_q[STG_DEQUAN];
   assign bus.start_idct    = start_q[STG_IDCT];
   assign bus.start_ycc2rgb = start_q[STG_YCC];
   assign bus.block_idx     = idx_q;
   assign bus.busy          = busy_q;
   assign bus.valid         = valid_q;
   assign bus.error         = error_q;
endmodule

// File: tb/tb_jpeg_dec_controller.sv
// Directed + randomised bench for jpeg_dec_controller; expected timelines come from per-stage delays.
module tb_jpeg_dec_controller;
   import jpeg_dec_pkg::*;

   localparam int unsigned NB   = 6;
   localparam int unsigned TO   = 16;
   localparam int unsigned BW   = idx_width(NB);
   localparam int          MAXC = 512;

   logic clk = 1'b0;
   logic rst;
   int   tests = 0;
   int   fails = 0;

   logic [3:0] exp_start [MAXC];
   logic [3:0] drv_done  [MAXC];
   int         exp_idx   [MAXC];
   bit         exp_busy  [MAXC];
   bit         exp_valid [MAXC];
   int         last_cyc;
   int         t_mark;

   jpeg_dec_controller_if #(.BW(BW)) bus ();

   jpeg_dec_controller #(.NUM_BLOCKS(NB), .TIMEOUT(TO), .BW(BW)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.master)
   );

   always #5 clk = ~clk;

   function automatic logic [3:0] starts();
      return {bus.start_ycc2rgb, bus.start_idct, bus.start_dequan, bus.start_huff};
   endfunction

   task automatic check(input string tag, input int cyc, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s cycle=%0d observed=%0h expected=%0h", tag, cyc, obs, exp);
      end
   endtask

   task automatic drive_done(input logic [3:0] v);
      bus.done_huff    = v[0];
      bus.done_dequan  = v[1];
      bus.done_idct    = v[2];
      bus.done_ycc2rgb = v[3];
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, "_start"}, -1, 32'(starts()), 32'd0);
      check({tag, "_idx"},   -1, 32'(bus.block_idx), 32'd0);
      check({tag, "_busy"},  -1, 32'(bus.busy), 32'd0);
      check({tag, "_valid"}, -1, 32'(bus.valid), 32'd0);
      check({tag, "_error"}, -1, 32'(bus.error), 32'd0);
   endtask

   task automatic do_reset();
      bus.enable = 1'b0;
      drive_done('0);
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
   endtask

   // Frame timeline: cycle 0 = IDLE with enable, each stage lasts d+1 cycles, NEXT 1, DONE 1.
   task automatic plan(input int dmin, input int dmax, input bit spur);
      int t;
      int d;
      for (int i = 0; i < MAXC; i++) begin
         exp_start[i] = '0;
         drv_done[i]  = '0;
         exp_idx[i]   = 0;
         exp_busy[i]  = 1'b0;
         exp_valid[i] = 1'b0;
      end
      t = 1;
      for (int b = 0; b < int'(NB); b++) begin
         for (int s = 0; s < 4; s++) begin
            d = int'($urandom_range(dmax, dmin));
            exp_start[t] = 4'(1 << s);
            for (int k = t; k <= t + d; k++) begin
               exp_idx[k]  = b;
               exp_busy[k] = 1'b1;
            end
            drv_done[t + d][s] = 1'b1;
            if (spur && s == 0) begin
               drv_done[t][0]     = 1'b1;
               drv_done[t + 1][2] = 1'b1;
            end
            if (b == int'(NB) - 1 && s == 2) t_mark = t;
            t += d + 1;
         end
         exp_idx[t]  = b;
         exp_busy[t] = 1'b1;
         if (spur) drv_done[t][3] = 1'b1;
         t++;
      end
      exp_valid[t]   = 1'b1;
      exp_busy[t]    = 1'b1;
      exp_idx[t]     = int'(NB) - 1;
      exp_idx[t + 1] = int'(NB) - 1;
      last_cyc       = t + 1;
   endtask

   task automatic run(input int upto, input bit hold_en);
      for (int n = 0; n <= upto; n++) begin
         if (n > 0) begin
            check("start", n, 32'(starts()), 32'(exp_start[n]));
            check("block_idx", n, 32'(bus.block_idx), 32'(exp_idx[n]));
            check("busy", n, 32'(bus.busy), 32'(exp_busy[n]));
            check("valid", n, 32'(bus.valid), 32'(exp_valid[n]));
            check("error", n, 32'(bus.error), 32'd0);
         end
         drive_done(drv_done[n]);
         bus.enable = hold_en || (n == 0);
         @(posedge clk); #1;
      end
      drive_done('0);
   endtask

   initial begin
      rst = 1'b1;
      bus.enable = 1'b0;
      drive_done('0);
      repeat (3) @(posedge clk);
      #1;
      check_all_zero("reset");
      rst = 1'b0;
      @(posedge clk); #1;
      check("post_reset_start", -1, 32'(starts()), 32'd0);
      check("post_reset_busy", -1, 32'(bus.busy), 32'd0);

      // Fixed 3-cycle stage latency
      plan(3, 3, 1'b0);
      run(last_cyc, 1'b0);

      // Spurious dones: coincident done_huff, done_idct in HUFF, done_ycc2rgb in NEXT
      plan(1, 8, 1'b1);
      run(last_cyc, 1'b0);

      // Every done lands in the watchdog-expiry cycle
      plan(int'(TO) - 1, int'(TO) - 1, 1'b0);
      run(last_cyc, 1'b0);

      repeat (3) begin
         plan(1, int'(TO) - 1, 1'b0);
         run(last_cyc, 1'b0);
      end

      // Watchdog: DEQUAN entered at cycle 5 and never completed
      for (int n = 0; n <= 27; n++) begin
         if (n > 0) begin
            check("to_start", n, 32'(starts()),
                  (n == 1 || n == 27) ? 32'd1 : (n == 5) ? 32'd2 : 32'd0);
            check("to_error", n, 32'(bus.error), (n >= 21 && n <= 26) ? 32'd1 : 32'd0);
            check("to_busy", n, 32'(bus.busy), (n == 26) ? 32'd0 : 32'd1);
            check("to_idx", n, 32'(bus.block_idx), 32'd0);
            check("to_valid", n, 32'(bus.valid), 32'd0);
         end
         drive_done((n == 4) ? 4'b0001 : 4'b0000);
         bus.enable = (n != 25);
         @(posedge clk); #1;
      end
      do_reset();

      // Reset while block NB-1 is in IDCT
      plan(3, 3, 1'b0);
      run(t_mark + 1, 1'b0);
      check("pre_rst_idx", t_mark + 2, 32'(bus.block_idx), 32'(NB - 1));
      do_reset();
      check_all_zero("mid_rst");
      plan(1, int'(TO) - 1, 1'b0);
      run(last_cyc, 1'b0);

      // enable held high through DONE: one IDLE cycle then the next frame starts
      plan(2, 5, 1'b0);
      run(last_cyc, 1'b1);
      check("restart_start", last_cyc + 1, 32'(starts()), 32'd1);
      check("restart_idx", last_cyc + 1, 32'(bus.block_idx), 32'd0);
      check("restart_busy", last_cyc + 1, 32'(bus.busy), 32'd1);
      do_reset();

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
